usb_tx_packet_sequencer: RTL

// Parametrised next-generation USB transmit packet sequencer. Accepts a PID and payload length from the

---
 rtl/usb_tx_packet_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/usb_tx_packet_sequencer.sv
// USB transmit packet sequencer.
// Walks a packet through SYNC, PID, DATA, CRC and EOP phases. Each phase is
// paced by byte_done strobes from the serializer. Illegal PIDs, oversize
// payloads and abort requests all route through a one-cycle ERROR state.
module usb_tx_packet_sequencer #(
  parameter int MAX_PKT_BYTES = 64,
  parameter int SYNC_BYTES    = 1,
  parameter int CRC_BYTES     = 2,
  parameter int HS_PIDS       = 0,
  parameter int LW            = $clog2(MAX_PKT_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_start,
  input  logic [3:0]    tx_pid,
  input  logic [LW-1:0] tx_len,
  input  logic          byte_done,
  input  logic          eop_done,
  input  logic          abort,
  output logic          tx_busy,
  output logic          tx_error,
  output logic          tx_done,
  output logic          data_rd,
  output logic [2:0]    state_out,
  output logic [3:0]    pid_out,
  output logic [LW-1:0] byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_EOP   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  // Last phase-counter value before leaving SYNC / CRC (counter never wraps).
  localparam logic [1:0]  SYNC_LAST = 2'(SYNC_BYTES - 1);
  localparam logic [1:0]  CRC_LAST  = 2'(CRC_BYTES - 1);
  localparam logic [LW:0] MAX_LEN   = (LW + 1)'(MAX_PKT_BYTES);

  state_t        state, state_nx;
  logic [3:0]    pid_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic [1:0]    phase;
  logic          done_q;

  logic capture, phase_inc, cnt_inc, done_nx, start_ok;

  // Data PIDs carry a payload and CRC; the high-speed ones only when enabled.
  function automatic logic is_data_pid(input logic [3:0] p);
    case (p)
      4'b0011, 4'b1011: return 1'b1;
      4'b0111, 4'b1111: return (HS_PIDS != 0);
      default:          return 1'b0;
    endcase
  endfunction

  // Handshake PIDs go from PID straight to EOP.
  function automatic logic is_hs_pid(input logic [3:0] p);
    case (p)
      4'b0010, 4'b1010, 4'b1110: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Payload length only matters for data PIDs.
  assign start_ok = is_hs_pid(tx_pid) ||
                    (is_data_pid(tx_pid) && ({1'b0, tx_len} <= MAX_LEN));

  assign tx_done   = done_q;
  assign state_out = state;
  assign pid_out   = pid_q;
  assign byte_cnt  = cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Captured packet fields, payload count, phase counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pid_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      phase  <= '0;
      done_q <= 1'b0;
    end else begin
      if (capture) begin
        pid_q <= tx_pid;
        len_q <= tx_len;
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + LW'(1);
      end
      if (state_nx != state) phase <= '0;
      else if (phase_inc)    phase <= phase + 2'd1;
      done_q <= done_nx;
    end
  end

  // Next-state and output decode; abort beats byte_done in SYNC..CRC.
  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    phase_inc = 1'b0;
    cnt_inc   = 1'b0;
    done_nx   = 1'b0;
    data_rd   = 1'b0;
    tx_busy   = (state != S_IDLE);
    tx_error  = (state == S_ERROR);
    case (state)
      S_IDLE: begin
        if (tx_start) begin
          capture  = 1'b1;
          state_nx = start_ok ? S_SYNC : S_ERROR;
        end
      end
      S_SYNC: begin
        if (abort) state_nx = S_ERROR;
        else if (byte_done) begin
          if (phase == SYNC_LAST) state_nx = S_PID;
          else                    phase_inc = 1'b1;
        end
      end
      S_PID: begin
        if (abort) state_nx = S_ERROR;
        else if (byte_done) begin
          if (is_data_pid(pid_q)) state_nx = (len_q != '0) ? S_DATA : S_CRC;
          else                    state_nx = S_EOP;
        end
      end
      S_DATA: begin
        if (abort) state_nx = S_ERROR;
        else if (byte_done) begin
          data_rd = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_q + LW'(1) == len_q) state_nx = S_CRC;
        end
      end
      S_CRC: begin
        if (abort) state_nx = S_ERROR;
        else if (byte_done) begin
          if (phase == CRC_LAST) state_nx = S_EOP;
          else                   phase_inc = 1'b1;
        end
      end
      S_EOP: begin
        if (eop_done) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
